// File: rtl/cnn_sram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port SRAM between NUM_REQ CNN requesters, with zero-fill after reset.
// Optional per-requester stall counters are built when CNN_SRAM_ARB_PERF_EN is defined.
module cnn_sram_port_arbiter #(
    parameter int BITS       = 16,
    parameter int WORD_DEPTH = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*BITS-1:0]       req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*BITS-1:0]       rsp_rdata,
    output logic                          init_done,
    output logic [1:0]                    ram_ce,
    output logic [1:0]                    ram_we,
    output logic [2*ADDR_WIDTH-1:0]       ram_addr,
    output logic [2*BITS-1:0]             ram_wd,
    input  logic [2*BITS-1:0]             ram_rd,
    output logic [NUM_REQ*16-1:0]         perf_stall_cnt
);
    localparam int IDXW  = $clog2(NUM_REQ);
    localparam int FILLW = ADDR_WIDTH - 1;
    localparam logic [FILLW-1:0] FILL_LAST = FILLW'(WORD_DEPTH / 2 - 1);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [FILLW-1:0]      fill_k;
    logic [IDXW-1:0]       ptr;
    logic                  g0_vld, g1_vld;
    logic [IDXW-1:0]       g0_idx, g1_idx;
    logic [ADDR_WIDTH-1:0] g0_addr;
    logic                  g0_we;
    logic [IDXW-1:0]       last_idx, ptr_next;
    logic [1:0]            rsp_vld_p1;
    logic [IDXW-1:0]       rsp_idx_p1 [2];

    function automatic logic conflict(input logic [ADDR_WIDTH-1:0] a0, input logic we0,
                                      input logic [ADDR_WIDTH-1:0] a1, input logic we1);
        return (a0 == a1) && (we0 || we1);
    endfunction

    // Port0 takes the first valid requester from ptr; port1 the next one that does not conflict.
    always_comb begin
        int j;
        j       = 0;
        g0_vld  = 1'b0;
        g0_idx  = '0;
        g1_vld  = 1'b0;
        g1_idx  = '0;
        g0_addr = '0;
        g0_we   = 1'b0;
        for (int s = 0; s < NUM_REQ; s++) begin
            j = int'(ptr) + s;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (state == ST_RUN && req_valid[j]) begin
                if (!g0_vld) begin
                    g0_vld  = 1'b1;
                    g0_idx  = IDXW'(j);
                    g0_addr = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                    g0_we   = req_we[j];
                end else if (!g1_vld && !conflict(g0_addr, g0_we,
                                                  req_addr[j*ADDR_WIDTH +: ADDR_WIDTH], req_we[j])) begin
                    g1_vld = 1'b1;
                    g1_idx = IDXW'(j);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (g0_vld) req_ready[g0_idx] = 1'b1;
        if (g1_vld) req_ready[g1_idx] = 1'b1;
    end

    assign last_idx = g1_vld ? g1_idx : g0_idx;
    assign ptr_next = (int'(last_idx) == NUM_REQ - 1) ? '0 : IDXW'(int'(last_idx) + 1);

    // Fill writes are held off while reset is asserted so the macro sees no strobes.
    always_comb begin
        ram_ce   = '0;
        ram_we   = '0;
        ram_addr = '0;
        ram_wd   = '0;
        if (state == ST_INIT) begin
            if (rst_n) begin
                ram_ce   = 2'b11;
                ram_we   = 2'b11;
                ram_addr = {fill_k, 1'b1, fill_k, 1'b0};
            end
        end else begin
            if (g0_vld) begin
                ram_ce[0]                  = 1'b1;
                ram_we[0]                  = req_we[g0_idx];
                ram_addr[0 +: ADDR_WIDTH]  = req_addr[g0_idx*ADDR_WIDTH +: ADDR_WIDTH];
                ram_wd[0 +: BITS]          = req_wdata[g0_idx*BITS +: BITS];
            end
            if (g1_vld) begin
                ram_ce[1]                          = 1'b1;
                ram_we[1]                          = req_we[g1_idx];
                ram_addr[ADDR_WIDTH +: ADDR_WIDTH] = req_addr[g1_idx*ADDR_WIDTH +: ADDR_WIDTH];
                ram_wd[BITS +: BITS]               = req_wdata[g1_idx*BITS +: BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            fill_k     <= '0;
            ptr        <= '0;
            rsp_vld_p1 <= '0;
        end else begin
            rsp_vld_p1[0] <= g0_vld && !req_we[g0_idx];
            rsp_vld_p1[1] <= g1_vld && !req_we[g1_idx];
            if (state == ST_INIT) begin
                fill_k <= fill_k + FILLW'(1);
                if (fill_k == FILL_LAST) state <= ST_RUN;
            end else if (g0_vld) begin
                ptr <= ptr_next;
            end
        end
    end

    // ---- stage p1: requester tag of each port's read, aligned with the RAM's registered data
    always_ff @(posedge clk) begin
        rsp_idx_p1[0] <= g0_idx;
        rsp_idx_p1[1] <= g1_idx;
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int p = 0; p < 2; p++) begin
            if (rsp_vld_p1[p]) begin
                rsp_valid[rsp_idx_p1[p]]              = 1'b1;
                rsp_rdata[rsp_idx_p1[p]*BITS +: BITS] = ram_rd[p*BITS +: BITS];
            end
        end
    end

    assign init_done = (state == ST_RUN);

`ifdef CNN_SRAM_ARB_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n) begin
                stall_cnt[i] <= '0;
            end else if (state == ST_RUN && req_valid[i] && !req_ready[i]) begin
                stall_cnt[i] <= sat_inc(stall_cnt[i]);
            end
        end
    end

    always_comb begin
        perf_stall_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) perf_stall_cnt[i*16 +: 16] = stall_cnt[i];
    end
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cnn_sram_port_arbiter.sv
// Randomised and directed bench for cnn_sram_port_arbiter against a behavioural memory/arbitration model.
module tb_cnn_sram_port_arbiter;
    localparam int BITS  = 16;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int N     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*BITS-1:0] req_wdata, rsp_rdata;
    logic              init_done;
    logic [1:0]        ram_ce, ram_we;
    logic [2*AW-1:0]   ram_addr;
    logic [2*BITS-1:0] ram_wd, ram_rd;
    logic [N*16-1:0]   perf_stall_cnt;

    cnn_sram_port_arbiter #(.BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .init_done(init_done), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wd(ram_wd), .ram_rd(ram_rd), .perf_stall_cnt(perf_stall_cnt)
    );

    // Dual-port SRAM with 1-cycle registered read; scramble fills it with garbage at power-up.
    logic scramble = 1'b1;
    logic [BITS-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= BITS'($urandom);
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (ram_ce[p]) begin
                    if (ram_we[p]) sram[ram_addr[p*AW +: AW]] <= ram_wd[p*BITS +: BITS];
                    else ram_rd[p*BITS +: BITS] <= sram[ram_addr[p*AW +: AW]];
                end
            end
        end
    end

    int tests = 0;
    int fails = 0;

    // Reference model: ideal memory contents, rotation pointer, stall tallies.
    logic [BITS-1:0] mem_m [DEPTH];
    int ptr_m, first_m, second_m;
    int stall_m [N];

    task automatic model_reset();
        ptr_m = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        for (int i = 0; i < N; i++) stall_m[i] = 0;
    endtask

    task automatic model_grant(output logic [N-1:0] g);
        int j, fa, sa;
        first_m  = -1;
        second_m = -1;
        for (int s = 0; s < N; s++) begin
            j = (ptr_m + s) % N;
            if (req_valid[j]) begin
                if (first_m < 0) begin
                    first_m = j;
                end else if (second_m < 0) begin
                    fa = int'(req_addr[first_m*AW +: AW]);
                    sa = int'(req_addr[j*AW +: AW]);
                    if (!(fa == sa && (req_we[j] || req_we[first_m]))) second_m = j;
                end
            end
        end
        g = '0;
        if (first_m >= 0) g[first_m] = 1'b1;
        if (second_m >= 0) g[second_m] = 1'b1;
    endtask

    task automatic model_commit(input logic [N-1:0] g, output logic [N-1:0] rv,
                                output logic [N*BITS-1:0] rd);
        rv = '0;
        rd = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i] && !req_we[i]) begin
                rv[i] = 1'b1;
                rd[i*BITS +: BITS] = mem_m[req_addr[i*AW +: AW]];
            end
            if (req_valid[i] && !g[i] && stall_m[i] < 65535) stall_m[i]++;
        end
        for (int i = 0; i < N; i++)
            if (g[i] && req_we[i]) mem_m[req_addr[i*AW +: AW]] = req_wdata[i*BITS +: BITS];
        if (second_m >= 0) ptr_m = (second_m + 1) % N;
        else if (first_m >= 0) ptr_m = (first_m + 1) % N;
    endtask

    function automatic logic [N*BITS-1:0] masked(input logic [N*BITS-1:0] d, input logic [N-1:0] m);
        logic [N*BITS-1:0] r;
        r = d;
        for (int i = 0; i < N; i++) if (!m[i]) r[i*BITS +: BITS] = '0;
        return r;
    endfunction

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [BITS-1:0] wd);
        req_valid[i]            = 1'b1;
        req_we[i]               = we;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*BITS +: BITS] = wd;
    endtask

    // One RUN cycle: sample ready before the edge, responses after it; ends on the next negedge.
    task automatic step(output logic [N-1:0] ro, output logic [N-1:0] re,
                        output logic [N-1:0] vo, output logic [N-1:0] ve,
                        output logic [N*BITS-1:0] dobs, output logic [N*BITS-1:0] dexp);
        #1;
        ro = req_ready;
        model_grant(re);
        model_commit(re, ve, dexp);
        @(posedge clk);
        #1;
        vo   = rsp_valid;
        dobs = rsp_rdata;
        @(negedge clk);
    endtask

    task automatic do_reset_init();
        clear_reqs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DEPTH / 2) @(negedge clk);
        model_reset();
    endtask

    task automatic test_reset();
        int bad;
        logic [2*AW-1:0] ea;
        logic [N-1:0] ro, re, vo, ve;
        logic [N*BITS-1:0] dobs, dexp;
        clear_reqs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        scramble = 1'b0;
        tests++; if (req_ready !== '0) begin fails++; $display("FAIL rst_ready: got %b required 0", req_ready); end
        tests++; if (rsp_valid !== '0) begin fails++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        tests++; if (ram_ce !== 2'b00) begin fails++; $display("FAIL rst_ram_ce: got %b required 00", ram_ce); end
        tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL rst_init_done: got %b required 0", init_done); end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '1;
        bad = 0;
        for (int k = 0; k < DEPTH / 2; k++) begin
            #1;
            ea = {AW'(2*k + 1), AW'(2*k)};
            if (ram_ce !== 2'b11 || ram_we !== 2'b11 || ram_addr !== ea || ram_wd !== '0 ||
                init_done !== 1'b0 || req_ready !== '0) bad++;
            @(negedge clk);
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL init_fill: %0d bad cycles, required 0", bad); end
        clear_reqs();
        model_reset();
        #1;
        tests++; if (init_done !== 1'b1) begin fails++; $display("FAIL init_done_rise: got %b required 1", init_done); end
        set_req(0, 1'b0, AW'(37), '0);
        step(ro, re, vo, ve, dobs, dexp);
        tests++; if (ro !== 4'b0001) begin fails++; $display("FAIL rd37_ready: got %b required 0001", ro); end
        tests++; if (vo !== 4'b0001 || dobs[15:0] !== 16'h0000)
            begin fails++; $display("FAIL rd37_data: got v=%b d=%h required v=0001 d=0000", vo, dobs[15:0]); end
    endtask

    task automatic test_write_read();
        logic [N-1:0] ro, re, vo, ve;
        logic [N*BITS-1:0] dobs, dexp;
        clear_reqs();
        set_req(2, 1'b1, AW'(5), 16'hBEEF);
        step(ro, re, vo, ve, dobs, dexp);
        tests++; if (ro !== 4'b0100 || vo !== 4'b0000)
            begin fails++; $display("FAIL wr5: got ready=%b v=%b required 0100/0000", ro, vo); end
        clear_reqs();
        set_req(2, 1'b0, AW'(5), '0);
        step(ro, re, vo, ve, dobs, dexp);
        tests++; if (ro !== 4'b0100 || vo !== 4'b0100 || dobs[2*BITS +: BITS] !== 16'hBEEF)
            begin fails++; $display("FAIL rd5: got ready=%b v=%b d=%h required 0100/0100/beef", ro, vo, dobs[2*BITS +: BITS]); end
        clear_reqs();
        step(ro, re, vo, ve, dobs, dexp);
        tests++; if (vo !== 4'b0000) begin fails++; $display("FAIL rd5_once: got v=%b required 0000", vo); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] ro, re, vo, ve;
        logic [N*BITS-1:0] dobs, dexp;
        logic [N-1:0] exp_g [3];
        exp_g[0] = 4'b0011; exp_g[1] = 4'b1100; exp_g[2] = 4'b0011;
        clear_reqs();
        set_req(3, 1'b0, AW'(100), '0);
        step(ro, re, vo, ve, dobs, dexp);
        for (int c = 0; c < 3; c++) begin
            clear_reqs();
            for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(40 + 4*c + i), '0);
            step(ro, re, vo, ve, dobs, dexp);
            tests++; if (ro !== exp_g[c]) begin fails++; $display("FAIL rr_grant c%0d: got %b required %b", c, ro, exp_g[c]); end
            tests++; if (vo !== exp_g[c] || masked(dobs, ve) !== masked(dexp, ve))
                begin fails++; $display("FAIL rr_rsp c%0d: got v=%b d=%h required v=%b d=%h", c, vo, dobs, exp_g[c], dexp); end
        end
    endtask

    task automatic test_conflict();
        logic [N-1:0] ro, re, vo, ve;
        logic [N*BITS-1:0] dobs, dexp;
        clear_reqs();
        set_req(0, 1'b1, AW'(9), 16'h1234);
        set_req(1, 1'b0, AW'(9), '0);
        set_req(3, 1'b0, AW'(20), '0);
        step(ro, re, vo, ve, dobs, dexp);
        tests++; if (ro !== 4'b1001) begin fails++; $display("FAIL cf_grant: got %b required 1001", ro); end
        clear_reqs();
        set_req(1, 1'b0, AW'(9), '0);
        step(ro, re, vo, ve, dobs, dexp);
        tests++; if (ro !== 4'b0010 || vo !== 4'b0010 || dobs[BITS +: BITS] !== 16'h1234)
            begin fails++; $display("FAIL cf_retry: got ready=%b v=%b d=%h required 0010/0010/1234", ro, vo, dobs[BITS +: BITS]); end
        clear_reqs();
    endtask

    task automatic test_reset_mid_init();
        int bad;
        clear_reqs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        tests++; if (ram_addr !== {AW'(201), AW'(200)}) begin fails++; $display("FAIL mid_fill100: got %h required %h", ram_addr, {AW'(201), AW'(200)}); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (ram_ce !== 2'b00 || init_done !== 1'b0)
            begin fails++; $display("FAIL mid_rst: got ce=%b done=%b required 00/0", ram_ce, init_done); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < DEPTH / 2; k++) begin
            #1;
            if (init_done !== 1'b0 || ram_ce !== 2'b11 || ram_addr !== {AW'(2*k + 1), AW'(2*k)}) bad++;
            @(negedge clk);
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL mid_restart: %0d bad cycles, required 0", bad); end
        #1;
        tests++; if (init_done !== 1'b1) begin fails++; $display("FAIL mid_done: got %b required 1", init_done); end
        model_reset();
    endtask

    task automatic test_perf();
        logic [N-1:0] ro, re, vo, ve;
        logic [N*BITS-1:0] dobs, dexp;
        logic [15:0] exp1;
        do_reset_init();
        for (int c = 0; c < 3; c++) begin
            clear_reqs();
            set_req(0, 1'b1, AW'(9), BITS'(16'h1000 + c));
            set_req(1, 1'b0, AW'(9), '0);
            set_req(3, 1'b0, AW'(20), '0);
            step(ro, re, vo, ve, dobs, dexp);
            tests++; if (ro !== 4'b1001) begin fails++; $display("FAIL pf_grant c%0d: got %b required 1001", c, ro); end
        end
        clear_reqs();
        set_req(1, 1'b0, AW'(9), '0);
        step(ro, re, vo, ve, dobs, dexp);
        tests++; if (ro !== 4'b0010 || dobs[BITS +: BITS] !== 16'h1002)
            begin fails++; $display("FAIL pf_release: got ready=%b d=%h required 0010/1002", ro, dobs[BITS +: BITS]); end
        clear_reqs();
`ifdef CNN_SRAM_ARB_PERF_EN
        exp1 = 16'd3;
`else
        exp1 = 16'd0;
`endif
        tests++; if (perf_stall_cnt[16 +: 16] !== exp1)
            begin fails++; $display("FAIL pf_lane1: got %0d required %0d", perf_stall_cnt[16 +: 16], exp1); end
        tests++; if (perf_stall_cnt[0 +: 16] !== 16'd0)
            begin fails++; $display("FAIL pf_lane0: got %0d required 0", perf_stall_cnt[0 +: 16]); end
    endtask

    task automatic test_random();
        logic [N-1:0] ro, re, vo, ve, pend;
        logic [N*BITS-1:0] dobs, dexp;
        logic [15:0] ec;
        pend = '0;
        clear_reqs();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 55) begin
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), BITS'($urandom));
                    pend[i] = 1'b1;
                end
            end
            req_valid = pend;
            step(ro, re, vo, ve, dobs, dexp);
            tests++; if (ro !== re) begin fails++; $display("FAIL rnd_ready c%0d: got %b required %b", c, ro, re); end
            tests++; if (vo !== ve || masked(dobs, ve) !== masked(dexp, ve))
                begin fails++; $display("FAIL rnd_rsp c%0d: got v=%b d=%h required v=%b d=%h", c, vo, dobs, ve, dexp); end
            pend = pend & ~re;
        end
        clear_reqs();
        for (int i = 0; i < N; i++) begin
`ifdef CNN_SRAM_ARB_PERF_EN
            ec = 16'(stall_m[i]);
`else
            ec = 16'd0;
`endif
            tests++; if (perf_stall_cnt[i*16 +: 16] !== ec)
                begin fails++; $display("FAIL rnd_stall%0d: got %0d required %0d", i, perf_stall_cnt[i*16 +: 16], ec); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ram_rd = '0;
        clear_reqs();
        model_reset();
        test_reset();
        test_write_read();
        test_round_robin();
        test_conflict();
        test_reset_mid_init();
        test_perf();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
